// File: rtl/arith_shift_seq.sv
// Sequential signed right-shifter: accepts a word and a shift amount,
// performs one arithmetic right shift per clock, then presents the result
// together with a sticky bit (OR of everything shifted out of the LSB).
module arith_shift_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sticky_q;

  // Next-state logic: the load decides between SHIFT and DONE from the
  // incoming amount, SHIFT leaves on its last shift, DONE waits for the consumer.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            cnt_q    <= in_shamt;
            sticky_q <= 1'b0;
          end
        end
        SHIFT: begin
          // Count is at least 1 here, so the decrement never wraps.
          data_q   <= {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          sticky_q <= sticky_q | data_q[0];
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs decode directly from registered state.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
    out_data   = data_q;
    out_sticky = sticky_q;
  end

endmodule

// File: doc/arith_shift_seq.md
# arith_shift_seq

Sequential signed right-shifter for the arithmetic datapath. It sits directly upstream of the combinational `arith_shift1x4_right` stage. It accepts a signed word and a shift amount through a valid/ready handshake, then applies one arithmetic right shift per clock until the count is exhausted. It presents the result with a sticky bit (OR of all bits shifted out) on a valid/ready output port.

## Interface

**Parameters**
- `WIDTH`, default 4: data width in bits; the MSB is the sign bit.
- `CNT_W`, default 3: width of the shift-amount field; legal shift amounts are 0 to 2^CNT_W−1.

**Ports**
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: request present on `in_data`/`in_shamt`.
- `in_ready`, output, 1: block can accept a request this cycle.
- `in_data`, input, WIDTH: signed operand.
- `in_shamt`, input, CNT_W: number of 1-bit arithmetic right shifts.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result this cycle.
- `out_data`, output, WIDTH: shifted result.
- `out_sticky`, output, 1: OR of every bit shifted out of the LSB.
- `busy`, output, 1: high in SHIFT or DONE.

## Operation

**States**
- IDLE:
  - `in_ready`=1.
  - On `in_valid`:
    - load `in_data` into the data register;
    - load `in_shamt` into the count register;
    - clear sticky.
  - Next state is DONE if `in_shamt`==0, else SHIFT.
- SHIFT, on each edge:
  - data ← {data[WIDTH−1], data[WIDTH−1:1]};
  - sticky ← sticky | data[0];
  - count ← count−1.
  - When count==1 at the edge (last shift), next state is DONE.
- DONE:
  - `out_valid`=1.
  - `out_data`/`out_sticky` are held stable.
  - On `out_ready`, return to IDLE.

**Rules**
- `in_ready` is asserted only in IDLE. No request is accepted in DONE, even when `out_ready` is high in the same cycle.
- Input fields are captured only on the accept edge. Later changes to `in_data`/`in_shamt` are ignored.
- Sign extension: the MSB is replicated on every shift. Shift amounts ≥ WIDTH−1 yield all-sign-bits: 0…0 for non-negative, 1…1 for negative.
- There is no early exit. The block always performs exactly `in_shamt` shifts, so latency is deterministic.
- Sticky accumulates across all shifts, including shifts once the data has saturated. For a negative saturated value, sticky is therefore 1 if any extra shifts occur.
- `out_data` and `out_sticky` are registered and update only in SHIFT or on load. Outside DONE they are not qualified by `out_valid`.
- `busy` = (state != IDLE).

## Timing

**Reset**
- `rst` high at an edge forces IDLE, clears the data, count and sticky registers, and aborts any in-flight operation with no output.
- Values after reset: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_sticky`=0, `busy`=0.
- `rst` takes priority over a simultaneous `in_valid` or `out_ready`.

**Latency**
- The accept edge E0 is the edge where `in_valid`&&`in_ready`.
- `out_valid` goes high in the cycle after edge E0+`in_shamt`:
  - `in_shamt`=0 gives `out_valid` one cycle after accept;
  - `in_shamt`=7 gives it eight cycles after accept.

**Handshake**
- The output transfer completes on the edge where `out_valid`&&`out_ready`.
- `in_ready` rises in the following cycle.
- Minimum initiation interval is `in_shamt`+2 cycles.

**Backpressure**
- With `out_ready` low, DONE persists indefinitely.
- `out_data`, `out_sticky` and `out_valid` stay constant.

**Count**
- The count register never wraps. It is only decremented in SHIFT, where it is ≥1.

## Test plan

1. `in_data`=0110, `in_shamt`=1, `out_ready`=1 → `out_valid` 2 cycles after accept, `out_data`=0011 (+3), `out_sticky`=0.
2. `in_data`=1011, `in_shamt`=1 → `out_data`=1101 (−3), `out_sticky`=1. Then `in_data`=1011, `in_shamt`=2 → `out_data`=1110 (−2), `out_sticky`=1.
3. `in_data`=1000, `in_shamt`=3 → `out_data`=1111, `out_sticky`=0, latency 4 cycles. Then `in_shamt`=7 → `out_data`=1111, `out_sticky`=1, latency 8 cycles.
4. `in_data`=0001, `in_shamt`=0 → `out_data`=0001, `out_sticky`=0, `out_valid` 1 cycle after accept. Then `in_shamt`=1 → `out_data`=0000, `out_sticky`=1.
5. `out_ready` held low for 5 cycles in DONE → `out_data`/`out_sticky` stable, `in_ready`=0, and an `in_valid` pulse is ignored. Raising `out_ready` → transfer, then `in_ready`=1 next cycle.
6. `in_data`=0111, `in_shamt`=6, `rst` asserted 3 cycles after accept → next cycle `out_valid`=0, `out_data`=0000, `busy`=0, `in_ready`=1, and no output is produced for the aborted request.
